// File: rtl/sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect_if.sv
// ---------------------------------------------------------------------------
// sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect_if
//
// Purpose:
//   Groups the signals that pass through the RX link fault detector:
//   - the XGMII receive stream coming from the PCS;
//   - the link fault status stream going to the downstream timing adapter.
//
// Signals:
//   xgmii_rx_valid           qualifies xgmii_rx_data / xgmii_rx_ctrl
//   xgmii_rx_data [63:0]     eight lanes; lane n = bits [8n+7:8n]
//   xgmii_rx_ctrl [7:0]      per-lane control flag
//   link_fault_status_ready  downstream ready (status is a level stream)
//   link_fault_status_valid  status valid
//   link_fault_status_data   00 OK, 01 local fault, 10 remote fault
//
// Modports:
//   master  the side that drives XGMII and consumes status (PCS / bench)
//   slave   the detector itself
// ---------------------------------------------------------------------------
interface sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect_if;
  logic        xgmii_rx_valid;
  logic [63:0] xgmii_rx_data;
  logic [7:0]  xgmii_rx_ctrl;
  logic        link_fault_status_ready;
  logic        link_fault_status_valid;
  logic [1:0]  link_fault_status_data;

  modport master (
    output xgmii_rx_valid,
    output xgmii_rx_data,
    output xgmii_rx_ctrl,
    output link_fault_status_ready,
    input  link_fault_status_valid,
    input  link_fault_status_data
  );

  modport slave (
    input  xgmii_rx_valid,
    input  xgmii_rx_data,
    input  xgmii_rx_ctrl,
    input  link_fault_status_ready,
    output link_fault_status_valid,
    output link_fault_status_data
  );
endinterface

// File: rtl/sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect.sv
// ---------------------------------------------------------------------------
// sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect
//
// Purpose:
//   RX-side link fault detector. Watches the 64-bit XGMII receive stream
//   (two 4-lane columns per cycle), recognises local/remote fault sequence
//   ordered sets, and produces a registered 2-bit link fault status level.
//   A fault is asserted after SEQ_THRESHOLD consecutive sequences of the
//   same type; it is cleared after COL_WINDOW columns with no sequence.
//
// Ports:
//   clk    MAC RX clock
//   reset  asynchronous, active-high reset
//   bus    slave side of the detector interface (XGMII in, status out)
//
// Parameters:
//   COL_WINDOW     columns without a sequence before status returns to OK
//   SEQ_THRESHOLD  consecutive same-type sequences needed to assert a fault
//   CNT_W          column counter width; 2^CNT_W must exceed COL_WINDOW + 2
// ---------------------------------------------------------------------------
module sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect #(
  parameter int COL_WINDOW    = 128,
  parameter int SEQ_THRESHOLD = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic reset,
  sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect_if.slave bus
);

  localparam int SEQ_W = $clog2(SEQ_THRESHOLD + 1);
  localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(SEQ_THRESHOLD);
  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(COL_WINDOW);

  // Status is a level; downstream back-pressure has no meaning here.
  logic unused_ready;
  assign unused_ready = bus.link_fault_status_ready;

  // ---------------------------------------------------------------------
  // Per-column fault sequence recognition
  // ---------------------------------------------------------------------
  logic       col_is_seq [2];
  logic [1:0] col_type   [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_col
      logic [31:0] col_data;
      logic [3:0]  col_ctrl;
      assign col_data = bus.xgmii_rx_data[32*gi +: 32];
      assign col_ctrl = bus.xgmii_rx_ctrl[4*gi +: 4];

      // Only the first lane is a control character; the next two lanes are
      // zero and the last lane carries the fault code (01 local, 02 remote).
      // Other sequence codes are ordinary columns.
      assign col_is_seq[gi] = (col_ctrl == 4'b0001) &&
                              (col_data[7:0] == 8'h9C) &&
                              (col_data[23:8] == 16'h0000) &&
                              ((col_data[31:24] == 8'h01) ||
                               (col_data[31:24] == 8'h02));

      // 0x01 -> 2'b01 (local), 0x02 -> 2'b10 (remote)
      assign col_type[gi] = col_data[25:24];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic             valid_reg;
  logic [1:0]       status_reg,    status_next;
  logic [SEQ_W-1:0] seq_cnt_reg,   seq_cnt_next;
  logic [1:0]       last_type_reg, last_type_next;
  logic [CNT_W-1:0] col_cnt_reg,   col_cnt_next;

  // Columns are walked in order (0 then 1) so that both can update the
  // counters in a single cycle; column 1 therefore has the final say when
  // the two columns carry different types.
  always_comb begin
    status_next    = status_reg;
    seq_cnt_next   = seq_cnt_reg;
    last_type_next = last_type_reg;
    col_cnt_next   = col_cnt_reg;

    if (bus.xgmii_rx_valid) begin
      for (int c = 0; c < 2; c++) begin
        if (col_is_seq[c]) begin
          if (col_type[c] == last_type_next) begin
            if (seq_cnt_next < SEQ_MAX) begin
              seq_cnt_next = seq_cnt_next + 1'b1;
            end
          end else begin
            seq_cnt_next   = SEQ_W'(1);
            last_type_next = col_type[c];
          end
          col_cnt_next = '0;
          if (seq_cnt_next == SEQ_MAX) begin
            status_next = col_type[c];
          end
        end else begin
          if (col_cnt_next < COL_MAX) begin
            col_cnt_next = col_cnt_next + 1'b1;
          end
          // Window of quiet columns elapsed: forget everything seen so far.
          if (col_cnt_next >= COL_MAX) begin
            seq_cnt_next   = '0;
            last_type_next = 2'b00;
            status_next    = 2'b00;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg     <= 1'b0;
      status_reg    <= 2'b00;
      seq_cnt_reg   <= '0;
      last_type_reg <= 2'b00;
      col_cnt_reg   <= '0;
    end else begin
      valid_reg     <= 1'b1;
      status_reg    <= status_next;
      seq_cnt_reg   <= seq_cnt_next;
      last_type_reg <= last_type_next;
      col_cnt_reg   <= col_cnt_next;
    end
  end

  assign bus.link_fault_status_valid = valid_reg;
  assign bus.link_fault_status_data  = status_reg;

endmodule

// File: tb/tb_sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect.sv
// ---------------------------------------------------------------------------
// Directed testbench for sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// 1 time unit after the rising edge that consumed the inputs.
// ---------------------------------------------------------------------------
module tb_sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect;

  logic clk;
  logic reset;

  int checks_cnt;
  int failures_cnt;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_LOC = 2'b01;
  localparam logic [1:0] ST_REM = 2'b10;

  // column selectors for build_word: 0 idle, 1 local, 2 remote, 3 other 9C code
  localparam int C_IDLE = 0;
  localparam int C_LOC  = 1;
  localparam int C_REM  = 2;
  localparam int C_ODD  = 3;

  sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect_if rx_bus ();

  sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rx_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      failures_cnt++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s got=%0h t=%0t", tag, got, $time);
    end
  endtask

  function automatic logic [35:0] build_col(input int kind);
    // returns {ctrl[3:0], data[31:0]} for one column
    case (kind)
      C_LOC:   build_col = {4'b0001, 8'h01, 8'h00, 8'h00, 8'h9C};
      C_REM:   build_col = {4'b0001, 8'h02, 8'h00, 8'h00, 8'h9C};
      C_ODD:   build_col = {4'b0001, 8'h03, 8'h00, 8'h00, 8'h9C};
      default: build_col = {4'hF, 32'h07070707};
    endcase
  endfunction

  // One valid (or not) XGMII cycle, then sample outputs after the edge.
  task automatic drive_cycle(input logic vld, input int col0, input int col1);
    logic [35:0] c0;
    logic [35:0] c1;
    c0 = build_col(col0);
    c1 = build_col(col1);
    rx_bus.xgmii_rx_valid = vld;
    rx_bus.xgmii_rx_data  = {c1[31:0], c0[31:0]};
    rx_bus.xgmii_rx_ctrl  = {c1[35:32], c0[35:32]};
    @(posedge clk);
    #1;
  endtask

  task automatic expect_status(input string tag, input logic [1:0] st);
    check({tag, ".valid"}, 32'(rx_bus.link_fault_status_valid), 32'd1);
    check({tag, ".data"},  32'(rx_bus.link_fault_status_data),  32'(st));
  endtask

  initial begin
    checks_cnt   = 0;
    failures_cnt = 0;
    reset = 1'b1;
    rx_bus.link_fault_status_ready = 1'b1;
    rx_bus.xgmii_rx_valid = 1'b0;
    rx_bus.xgmii_rx_data  = {8{8'h07}};
    rx_bus.xgmii_rx_ctrl  = 8'hFF;

    // ---- reset state ----
    #2;
    check("rst.valid", 32'(rx_bus.link_fault_status_valid), 32'd0);
    check("rst.data",  32'(rx_bus.link_fault_status_data),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_release.valid", 32'(rx_bus.link_fault_status_valid), 32'd0);

    // ---- 20 idle cycles ----
    for (int i = 0; i < 20; i++) drive_cycle(1'b1, C_IDLE, C_IDLE);
    expect_status("idle20", ST_OK);

    // Ordinary 9C columns (code 03) and a malformed local sequence are not faults
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, C_ODD, C_ODD);
    expect_status("odd_code", ST_OK);
    for (int i = 0; i < 4; i++) begin
      rx_bus.xgmii_rx_valid = 1'b1;
      rx_bus.xgmii_rx_data  = {32'h07070707, 8'h01, 8'h00, 8'h00, 8'h9C};
      rx_bus.xgmii_rx_ctrl  = 8'hF3;   // lane 1 flagged as control
      @(posedge clk);
      #1;
    end
    expect_status("bad_ctrl", ST_OK);

    // ---- local fault in column 0, 4 cycles ----
    for (int i = 1; i <= 3; i++) begin
      drive_cycle(1'b1, C_LOC, C_IDLE);
      expect_status($sformatf("loc%0d", i), ST_OK);
    end
    drive_cycle(1'b1, C_LOC, C_IDLE);
    expect_status("loc4", ST_LOC);

    // ---- remote in both columns, 2 cycles ----
    drive_cycle(1'b1, C_REM, C_REM);
    expect_status("rem_x2_a", ST_LOC);
    drive_cycle(1'b1, C_REM, C_REM);
    expect_status("rem_x2_b", ST_REM);

    // ---- 64 idle cycles: clear exactly on the 128th column ----
    for (int i = 1; i <= 63; i++) drive_cycle(1'b1, C_IDLE, C_IDLE);
    expect_status("timeout_idle63", ST_REM);
    drive_cycle(1'b1, C_IDLE, C_IDLE);
    expect_status("timeout_idle64", ST_OK);

    // ---- local x3, remote x1, local x3, then one more local ----
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, C_LOC, C_IDLE);
    expect_status("mix_l3", ST_OK);
    drive_cycle(1'b1, C_REM, C_IDLE);
    expect_status("mix_r1", ST_OK);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, C_LOC, C_IDLE);
    expect_status("mix_l3b", ST_OK);
    drive_cycle(1'b1, C_LOC, C_IDLE);
    expect_status("mix_l4", ST_LOC);

    // ---- valid low for 200 cycles: everything holds (col_cnt = 1) ----
    for (int i = 0; i < 200; i++) drive_cycle(1'b0, C_IDLE, C_IDLE);
    expect_status("hold200", ST_LOC);
    // col_cnt 1 + 126 = 127 -> still faulted; one more cycle -> 129 sat 128
    for (int i = 0; i < 63; i++) drive_cycle(1'b1, C_IDLE, C_IDLE);
    expect_status("hold_idle63", ST_LOC);
    drive_cycle(1'b1, C_IDLE, C_IDLE);
    expect_status("hold_idle64", ST_OK);

    // ---- different types in one cycle: column 1 wins ----
    drive_cycle(1'b1, C_LOC, C_REM);
    expect_status("col1_wins_0", ST_OK);
    drive_cycle(1'b1, C_REM, C_IDLE);
    expect_status("col1_wins_1", ST_OK);
    drive_cycle(1'b1, C_REM, C_IDLE);
    expect_status("col1_wins_2", ST_OK);
    drive_cycle(1'b1, C_REM, C_IDLE);
    expect_status("col1_wins_3", ST_REM);

    // ---- asynchronous reset while remote fault is active ----
    #3;
    reset = 1'b1;
    #1;
    check("async_rst.valid", 32'(rx_bus.link_fault_status_valid), 32'd0);
    check("async_rst.data",  32'(rx_bus.link_fault_status_data),  32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive_cycle(1'b1, C_REM, C_IDLE);
      expect_status($sformatf("post_rst_rem%0d", i), ST_OK);
    end
    drive_cycle(1'b1, C_REM, C_IDLE);
    expect_status("post_rst_rem4", ST_REM);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule

// File: doc/sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect.md
Name: sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect

Overview:
- RX-side link fault detector for the 10G MAC, per IEEE 802.3 Clause 46 link fault signalling.
- Monitors the 64-bit XGMII receive stream from the PCS, two columns per cycle, and qualifies local/remote fault sequence ordered sets.
- Produces the 2-bit registered link fault status stream that feeds the link_fault_status_export timing adapter directly downstream.

Parameters:
- COL_WINDOW, 128: columns without a fault sequence before status returns to OK.
- SEQ_THRESHOLD, 4: consecutive same-type fault sequences needed to assert a fault.
- CNT_W, 8: width of the column counter; must satisfy 2^CNT_W > COL_WINDOW + 2.

Ports:
- clk  in  1  MAC RX clock, 156.25 MHz.
- reset  in  1  asynchronous, active-high reset.
- xgmii_rx_valid  in  1  qualifies xgmii_rx_data/ctrl; cycles with 0 are ignored entirely.
- xgmii_rx_data  in  64  lanes 0-7, lane n = bits [8n+7:8n]; column 0 = lanes 0-3, column 1 = lanes 4-7.
- xgmii_rx_ctrl  in  8  per-lane control flag.
- link_fault_status_ready  in  1  downstream ready; ignored, because status is a level stream.
- link_fault_status_valid  out  1  status valid.
- link_fault_status_data  out  2  00 = OK, 01 = local fault, 10 = remote fault; 11 is never driven.

Behaviour:
- Reset state: status_data = 00, status_valid = 0, seq_cnt = 0, last_type = 00, col_cnt = 0.
- status_valid goes to 1 on the first clk edge after reset deasserts and stays 1; no bubbles.
- Fault sequence in column c (c = 0 or 1, base lane b = 4c). All of the following must hold:
  - ctrl[b] = 1, with data lane b = 0x9C;
  - ctrl[b+1..b+3] = 0;
  - lanes b+1 and b+2 = 0x00;
  - lane b+3 = 0x01 (local) or 0x02 (remote).
- Any other 0x9C sequence type is treated as an ordinary column, not a fault sequence.
- Per-sequence update, applied in column order (column 0 first, then column 1), both within the same cycle:
  - if type == last_type: seq_cnt = min(seq_cnt + 1, SEQ_THRESHOLD);
  - else: seq_cnt = 1 and last_type = type;
  - col_cnt = 0;
  - if seq_cnt reaches SEQ_THRESHOLD: status = type.
- Valid cycle with no fault sequence: col_cnt += 2, saturating at COL_WINDOW.
- Valid cycle where the only sequence is in column 0: col_cnt = 1, because column 1 follows it.
- Timeout: when col_cnt reaches ≥ COL_WINDOW, then on that same edge seq_cnt = 0, last_type = 00, status = 00.
- Type change: local → remote (or remote → local) resets seq_cnt to 1. Status keeps its old fault value until the new type reaches the threshold or a timeout occurs.
- Both columns carrying different types in one cycle: column 1 wins. last_type = column 1 type, seq_cnt = 1.
- Latency: status_data changes on the clk edge that samples the qualifying (threshold-reaching) sequence, so it is visible 1 cycle after that input cycle.
- xgmii_rx_valid = 0 cycles: all state holds, including col_cnt and status.
- Reset asserted mid-fault: status drops to 00 and valid drops to 0 immediately (asynchronous). Counters clear, and detection restarts from scratch.
- Output registers only; no combinational path from the inputs to the outputs.

Test Plan:
- Reset, then 20 cycles of idle (ctrl = 0xFF, data = 0x07 per lane): status_valid = 1 from the first post-reset cycle; status_data = 00 throughout.
- Local fault sequence in column 0 on 4 consecutive cycles: status_data = 01 exactly 1 cycle after the 4th sequence cycle; 00 before that.
- 2 cycles with remote sequences in both columns (4 sequences total): status_data = 10 after the 2nd cycle. Then 64 idle cycles (128 columns): status returns to 00 on the edge at which col_cnt reaches 128, and not 1 cycle earlier.
- Local ×3, remote ×1, local ×3 (one sequence per cycle): status stays 00 throughout. A 4th consecutive local sequence then gives 01.
- xgmii_rx_valid = 0 for 200 cycles while status = 01: status holds 01 and col_cnt does not advance.
- Assert reset for 1 cycle while status = 10: outputs become 00/0 asynchronously; 3 further remote sequences after reset keep status at 00.
